// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// alu_cmd_sequencer : FIFO-fed command initiator for a combinational ALU
// Revision 1.0
// =============================================================================
module alu_cmd_sequencer #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1,
   parameter int TAGW   = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [WIDTH-1:0]         cmd_in1,
   input  logic [WIDTH-1:0]         cmd_in2,
   input  logic [1:0]               cmd_sel,
   output logic [WIDTH-1:0]         alu_in1,
   output logic [WIDTH-1:0]         alu_in2,
   output logic [1:0]               alu_sel,
   input  logic [WIDTH-1:0]         alu_out1,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [1:0]               rsp_sel,
   output logic [TAGW-1:0]          rsp_tag,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2*WIDTH + 2 + TAGW;
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic [TAGW-1:0]   pend_tag_q, pend_tag_d;
   logic [3:0]        settle_q, settle_d;
   logic [WIDTH-1:0]  alu_in1_q, alu_in1_d;
   logic [WIDTH-1:0]  alu_in2_q, alu_in2_d;
   logic [1:0]        alu_sel_q, alu_sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_sel_q, rsp_sel_d;
   logic [TAGW-1:0]   rsp_tag_q, rsp_tag_d;

   logic w_full, w_empty, w_push, w_pop;

   // A full FIFO refuses the push even when a pop frees a slot on the same edge.
   assign w_full  = (count_q == FULL_CNT);
   assign w_empty = (count_q == '0);
   assign w_push  = cmd_valid && !w_full;
   assign w_pop   = (state_q == ST_IDLE) && !w_empty;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      tag_d       = tag_q;
      pend_tag_d  = pend_tag_q;
      settle_d    = settle_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_sel_d   = alu_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_sel_d   = rsp_sel_q;
      rsp_tag_d   = rsp_tag_q;

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         tag_d    = tag_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (!w_empty) begin
               {alu_in1_d, alu_in2_d, alu_sel_d, pend_tag_d} = mem_q[rd_ptr_q];
               settle_d = SETTLE_CNT;
               state_d  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            settle_d = settle_q - 4'd1;
            // Sample on the edge where the settle count reaches zero.
            if (settle_q == 4'd1) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = alu_out1;
               rsp_sel_d   = alu_sel_q;
               rsp_tag_d   = pend_tag_q;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tag_q       <= '0;
         pend_tag_q  <= '0;
         settle_q    <= '0;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_sel_q   <= '0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tag_q       <= tag_d;
         pend_tag_q  <= pend_tag_d;
         settle_q    <= settle_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_sel_q   <= rsp_sel_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {cmd_in1, cmd_in2, cmd_sel, tag_q};
      end
   end

   assign cmd_ready  = !w_full;
   assign alu_in1    = alu_in1_q;
   assign alu_in2    = alu_in2_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_sel    = rsp_sel_q;
   assign rsp_tag    = rsp_tag_q;
   assign busy       = (state_q != ST_IDLE) || !w_empty;
   assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_alu_cmd_sequencer : scoreboard bench, SETTLE=1 instance and SETTLE=3 instance
// Revision 1.0
// =============================================================================
module tb_alu_cmd_sequencer;

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] sel;
      logic [2:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       a_cmd_valid = 1'b0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 1'b0, a_busy;
   logic [3:0] a_in1 = '0, a_in2 = '0, a_alu_in1, a_alu_in2, a_alu_out1, a_rsp_data;
   logic [1:0] a_sel = '0, a_alu_sel, a_rsp_sel;
   logic [2:0] a_rsp_tag, a_fifo_count, a_tag = '0;
   exp_t       a_q[$];

   logic       b_cmd_valid = 1'b0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_busy;
   logic [3:0] b_in1 = '0, b_in2 = '0, b_alu_in1, b_alu_in2, b_alu_out1, b_rsp_data;
   logic [1:0] b_sel = '0, b_alu_sel, b_rsp_sel;
   logic [2:0] b_rsp_tag, b_fifo_count, b_tag = '0;
   logic [3:0] b_d1, b_d2;
   exp_t       b_q[$];

   function automatic logic [3:0] alu_f(input logic [3:0] x, input logic [3:0] y,
                                        input logic [1:0] s);
      case (s)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   // Instance b sees an ALU whose output lags its inputs by two clocks.
   assign a_alu_out1 = alu_f(a_alu_in1, a_alu_in2, a_alu_sel);
   always @(posedge clk) begin
      b_d1 <= alu_f(b_alu_in1, b_alu_in2, b_alu_sel);
      b_d2 <= b_d1;
   end
   assign b_alu_out1 = b_d2;

   alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .SETTLE(1), .TAGW(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_in1(a_in1), .cmd_in2(a_in2), .cmd_sel(a_sel),
      .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_sel(a_alu_sel), .alu_out1(a_alu_out1),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
      .rsp_sel(a_rsp_sel), .rsp_tag(a_rsp_tag), .busy(a_busy), .fifo_count(a_fifo_count));

   alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .SETTLE(3), .TAGW(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_in1(b_in1), .cmd_in2(b_in2), .cmd_sel(b_sel),
      .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_sel(b_alu_sel), .alu_out1(b_alu_out1),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
      .rsp_sel(b_rsp_sel), .rsp_tag(b_rsp_tag), .busy(b_busy), .fifo_count(b_fifo_count));

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin : mon_a
      exp_t x;
      if (rst_n && a_rsp_valid && a_rsp_ready) begin
         if (a_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_rsp actual=%0h expected=none t=%0t", a_rsp_data, $time);
         end else begin
            x = a_q.pop_front();
            chk("a_rsp_data", 32'(a_rsp_data), 32'(x.data));
            chk("a_rsp_sel",  32'(a_rsp_sel),  32'(x.sel));
            chk("a_rsp_tag",  32'(a_rsp_tag),  32'(x.tag));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t x;
      if (rst_n && b_rsp_valid && b_rsp_ready) begin
         if (b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_rsp actual=%0h expected=none t=%0t", b_rsp_data, $time);
         end else begin
            x = b_q.pop_front();
            chk("b_rsp_data", 32'(b_rsp_data), 32'(x.data));
            chk("b_rsp_sel",  32'(b_rsp_sel),  32'(x.sel));
            chk("b_rsp_tag",  32'(b_rsp_tag),  32'(x.tag));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic push(input bit sb, input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] s, input logic [3:0] e);
      int n = 0;
      if (!sb) begin a_cmd_valid = 1'b1; a_in1 = x; a_in2 = y; a_sel = s; end
      else     begin b_cmd_valid = 1'b1; b_in1 = x; b_in2 = y; b_sel = s; end
      @(negedge clk);
      while (!(sb ? b_cmd_ready : a_cmd_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", 32'(sb ? b_cmd_ready : a_cmd_ready), 32'd1);
      @(posedge clk);
      if (!sb) begin a_q.push_back('{e, s, a_tag}); a_tag++; end
      else     begin b_q.push_back('{e, s, b_tag}); b_tag++; end
      #1;
      if (!sb) a_cmd_valid = 1'b0;
      else     b_cmd_valid = 1'b0;
   endtask

   task automatic drain(input bit sb);
      int n = 0;
      while (n < 300 && (sb ? (b_q.size() != 0 || b_busy) : (a_q.size() != 0 || a_busy))) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_done", 32'(n < 300), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int n;
      logic [2:0] t0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_count", 32'(a_fifo_count), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_alu_in1", 32'(a_alu_in1), 32'd0);
      chk("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Four ops on C/A plus first-response latency
      a_rsp_ready = 1'b1;
      push(0, 4'hC, 4'hA, 2'd0, 4'h8);
      @(negedge clk) chk("lat_early0", 32'(a_rsp_valid), 32'd0);
      @(negedge clk);
      chk("lat_early1", 32'(a_rsp_valid), 32'd0);
      chk("drv_in1", 32'(a_alu_in1), 32'hC);
      chk("drv_in2", 32'(a_alu_in2), 32'hA);
      chk("drv_sel", 32'(a_alu_sel), 32'd0);
      @(negedge clk) chk("lat_valid", 32'(a_rsp_valid), 32'd1);
      @(posedge clk);
      #1;
      push(0, 4'hC, 4'hA, 2'd1, 4'hE);
      push(0, 4'hC, 4'hA, 2'd2, 4'h6);
      push(0, 4'hC, 4'hA, 2'd3, 4'h9);
      drain(0);

      // Reset while a command is in DRIVE
      push(0, 4'h3, 4'h5, 2'd0, 4'h1);
      @(posedge clk);
      #2;
      chk("mid_busy", 32'(a_busy), 32'd1);
      chk("mid_alu_in1", 32'(a_alu_in1), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("mrst_alu_in1", 32'(a_alu_in1), 32'd0);
      chk("mrst_alu_in2", 32'(a_alu_in2), 32'd0);
      chk("mrst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("mrst_rsp_data", 32'(a_rsp_data), 32'd0);
      chk("mrst_cmd_ready", 32'(a_cmd_ready), 32'd1);
      chk("mrst_count", 32'(a_fifo_count), 32'd0);
      chk("mrst_busy", 32'(a_busy), 32'd0);
      a_q.delete();
      a_tag = '0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mrst_no_rsp", 32'(a_rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Tag wrap: nine XOR-with-F commands, tags 0..7,0
      for (int i = 0; i < 9; i++) begin
         push(0, 4'(i), 4'hF, 2'd2, ~4'(i));
      end
      drain(0);

      // Fill with responses blocked, then hold backpressure for 10 cycles
      a_rsp_ready = 1'b0;
      t0 = a_tag;
      push(0, 4'h6, 4'h3, 2'd1, 4'h7);
      push(0, 4'hF, 4'h5, 2'd0, 4'h5);
      push(0, 4'h9, 4'h3, 2'd2, 4'hA);
      push(0, 4'h2, 4'h4, 2'd3, 4'h9);
      push(0, 4'h8, 4'h8, 2'd1, 4'h8);
      chk("full_count", 32'(a_fifo_count), 32'd4);
      chk("full_ready", 32'(a_cmd_ready), 32'd0);
      a_cmd_valid = 1'b1;
      a_in1 = 4'h1;
      a_in2 = 4'hE;
      a_sel = 2'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_data", 32'(a_rsp_data), 32'h7);
         chk("hold_sel", 32'(a_rsp_sel), 32'd1);
         chk("hold_tag", 32'(a_rsp_tag), 32'(t0));
         chk("hold_ready", 32'(a_cmd_ready), 32'd0);
      end
      chk("hold_count", 32'(a_fifo_count), 32'd4);
      @(posedge clk);
      #1;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_valid_low", 32'(a_rsp_valid), 32'd0);
      chk("hs_alu_prev", 32'(a_alu_in1), 32'h6);
      @(posedge clk);
      #1;
      chk("issue_next", 32'(a_alu_in1), 32'hF);
      chk("pop_count", 32'(a_fifo_count), 32'd3);
      chk("pop_ready", 32'(a_cmd_ready), 32'd1);
      @(negedge clk);
      @(posedge clk);
      a_q.push_back('{4'hF, 2'd2, a_tag});
      a_tag++;
      #1;
      a_cmd_valid = 1'b0;
      drain(0);

      // Push and pop on the same edge at fifo_count=2
      a_rsp_ready = 1'b0;
      push(0, 4'h7, 4'h1, 2'd0, 4'h1);
      push(0, 4'h7, 4'h1, 2'd1, 4'h7);
      push(0, 4'h7, 4'h1, 2'd2, 4'h6);
      chk("pp_pre", 32'(a_fifo_count), 32'd2);
      a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      a_rsp_ready = 1'b0;
      push(0, 4'h7, 4'h1, 2'd3, 4'h9);
      chk("pp_count", 32'(a_fifo_count), 32'd2);
      a_rsp_ready = 1'b1;
      drain(0);

      // SETTLE=3 instance against the lagging ALU
      b_rsp_ready = 1'b1;
      push(1, 4'hC, 4'hA, 2'd0, 4'h8);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!b_rsp_valid && n < 20);
      chk("b_latency", 32'(n), 32'd4);
      push(1, 4'hC, 4'hA, 2'd3, 4'h9);
      push(1, 4'h5, 4'h3, 2'd2, 4'h6);
      push(1, 4'hF, 4'h0, 2'd1, 4'hF);
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
